seg_scan_multi: RTL and testbench

- Parametrised multiplexed seven-segment scanner: the successor to the fixed 4-digit display driver in the organ top level.
- Drives DIGITS digits from a packed bus of 4-bit glyph codes, using the team's existing glyph code table.
- Adds tear-free double buffering with frame-boundary update, per-digit blink, PWM brightness and registered glitch-free outputs.
- Sits between the mode/note decode logic and the board anode/segment pins.

---
 rtl/seg_scan_multi.sv | 159 +++++++++++++++
 tb/tb_seg_scan_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment scanner: double-buffered glyph codes, per-digit blink,
// PWM brightness and registered one-hot anode / segment outputs.
module seg_scan_multi #(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned SCAN_DIV  = 131072,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned DUTY_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   codes,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DUTY_W-1:0]     duty,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            a_g,
    output logic                  frame_start
);

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BUF_W   = CODE_W * DIGITS;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SUB_DIV = SCAN_DIV >> DUTY_W;
    localparam int unsigned SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int unsigned BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(14);
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_DIV - 1);
    localparam logic [DUTY_W-1:0] PHASE_LAST = {DUTY_W{1'b1}};

    // Team glyph code table; codes 14 and 15 are blank.
    function automatic logic [SEG_W-1:0] glyph(input logic [CODE_W-1:0] c);
        logic [SEG_W-1:0] s;
        case (c)
            4'd0:    s = 7'b0110000;
            4'd1:    s = 7'b1101101;
            4'd2:    s = 7'b1111001;
            4'd3:    s = 7'b0110011;
            4'd4:    s = 7'b1011011;
            4'd5:    s = 7'b1011111;
            4'd6:    s = 7'b1110000;
            4'd7:    s = 7'b1000111;
            4'd8:    s = 7'b1100111;
            4'd9:    s = 7'b0001110;
            4'd10:   s = 7'b0110111;
            4'd11:   s = 7'b0000001;
            4'd12:   s = 7'b1111110;
            4'd13:   s = 7'b1001111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan position is kept as {phase, sub} so the PWM phase needs no divider.
    logic [SUB_W-1:0]  sub_q,   sub_d;
    logic [DUTY_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [BLK_W-1:0]  blk_q,   blk_d;
    logic              blink_on_q, blink_on_d;
    logic [BUF_W-1:0]  active_q,   active_d;
    logic [BUF_W-1:0]  pending_q,  pending_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DIGITS-1:0] an_d;
    logic [SEG_W-1:0]  a_g_d;
    logic              frame_start_d;

    logic              sub_end;
    logic              slot_end;
    logic              frame_end;
    logic [CODE_W-1:0] cur_code;
    logic              lit;

    always_comb begin
        sub_d         = sub_q;
        phase_d       = phase_q;
        idx_d         = idx_q;
        blk_d         = blk_q;
        blink_on_d    = blink_on_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pend_valid_d  = pend_valid_q;
        an_d          = '0;
        a_g_d         = '0;
        frame_start_d = 1'b0;

        sub_end   = (sub_q == SUB_LAST);
        slot_end  = sub_end && (phase_q == PHASE_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        sub_d   = sub_end ? '0 : sub_q + SUB_W'(1);
        phase_d = phase_q + DUTY_W'(sub_end);
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end

        if (blk_q == BLK_LAST) begin
            blk_d      = '0;
            blink_on_d = ~blink_on_q;
        end else begin
            blk_d = blk_q + BLK_W'(1);
        end

        // Active only changes at the frame boundary; a boundary-cycle load bypasses pending.
        if (load) begin
            if (frame_end) begin
                active_d     = codes;
                pend_valid_d = 1'b0;
            end else begin
                pending_d    = codes;
                pend_valid_d = 1'b1;
            end
        end else if (frame_end && pend_valid_q) begin
            active_d     = pending_q;
            pend_valid_d = 1'b0;
        end

        cur_code = active_q[CODE_W*idx_q +: CODE_W];
        lit      = (cur_code < CODE_BLANK)
                && (blink_on_q || !blink_mask[idx_q])
                && (phase_q <= duty);
        if (lit) begin
            an_d  = DIGITS'(1) << (IDX_LAST - idx_q);
            a_g_d = glyph(cur_code);
        end
        frame_start_d = (idx_q == '0) && (sub_q == '0) && (phase_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q        <= '0;
            phase_q      <= '0;
            idx_q        <= '0;
            blk_q        <= '0;
            blink_on_q   <= 1'b1;
            active_q     <= {DIGITS{CODE_BLANK}};
            pending_q    <= {DIGITS{CODE_BLANK}};
            pend_valid_q <= 1'b0;
            an           <= '0;
            a_g          <= '0;
            frame_start  <= 1'b0;
        end else begin
            sub_q        <= sub_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            blk_q        <= blk_d;
            blink_on_q   <= blink_on_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            an           <= an_d;
            a_g          <= a_g_d;
            frame_start  <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Bench for seg_scan_multi: glyph vector table, hand-written corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_seg_scan_multi;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 16;
    localparam int unsigned BLINK_DIV = 64;
    localparam int unsigned DUTY_W    = 2;
    localparam int FRAME = DIGITS * SCAN_DIV;

    logic              clk;
    logic              rst_n;
    logic [15:0]       codes;
    logic              load;
    logic [3:0]        blink_mask;
    logic [1:0]        duty;
    logic [3:0]        an;
    logic [6:0]        a_g;
    logic              frame_start;

    int n_tests;
    int n_fail;

    // Model state: edges since reset release plus the two buffers.
    int         mn;
    logic [3:0] m_act [DIGITS];
    logic [3:0] m_pend[DIGITS];
    bit         m_pv;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } glyph_vec_t;

    seg_scan_multi #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .codes      (codes),
        .load       (load),
        .blink_mask (blink_mask),
        .duty       (duty),
        .an         (an),
        .a_g        (a_g),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] c);
        logic [6:0] t [16];
        t = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111,
              7'b1110000, 7'b1000111, 7'b1100111, 7'b0001110, 7'b0110111, 7'b0000001,
              7'b1111110, 7'b1001111, 7'b0000000, 7'b0000000};
        return t[c];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, mn, act, exp);
        end
    endtask

    task automatic model_reset();
        mn = 0;
        m_pv = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            m_act[k]  = 4'd14;
            m_pend[k] = 4'd14;
        end
    endtask

    // One clock edge: predict outputs from current inputs and model, then compare.
    task automatic step();
        int         cnt, slot, ph;
        bit         bon, lit, boundary;
        logic [3:0] c, ea;
        logic [6:0] eg;
        bit         ef;
        cnt  = mn % SCAN_DIV;
        slot = (mn / SCAN_DIV) % DIGITS;
        ph   = cnt / (SCAN_DIV >> DUTY_W);
        bon  = ((mn / BLINK_DIV) % 2) == 0;
        c    = m_act[slot];
        lit  = (c < 4'd14) && (bon || !blink_mask[slot]) && (ph <= int'(duty));
        ea   = lit ? 4'(1 << (DIGITS - 1 - slot)) : 4'd0;
        eg   = lit ? ref_glyph(c) : 7'd0;
        ef   = (mn % FRAME) == 0;
        boundary = (mn % FRAME) == FRAME - 1;
        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (boundary) m_act[k] = codes[4*k +: 4];
                else          m_pend[k] = codes[4*k +: 4];
            end
            m_pv = !boundary;
        end else if (boundary && m_pv) begin
            for (int k = 0; k < DIGITS; k++) m_act[k] = m_pend[k];
            m_pv = 1'b0;
        end
        mn++;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(ea));
        check("a_g", 32'(a_g), 32'(eg));
        check("frame_start", 32'(frame_start), 32'(ef));
        check("an_onehot", 32'($countones(an) <= 1), 32'd1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_step(input logic [15:0] c);
        codes = c;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!frame_start && k < 200);
        check("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    glyph_vec_t vecs[16];
    int         dcnt[DIGITS];
    int         nz;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        codes = '0;
        load  = 1'b0;
        blink_mask = '0;
        duty  = 2'd3;
        model_reset();

        vecs = '{'{4'd0, 7'b0110000}, '{4'd1, 7'b1101101}, '{4'd2, 7'b1111001},
                 '{4'd3, 7'b0110011}, '{4'd4, 7'b1011011}, '{4'd5, 7'b1011111},
                 '{4'd6, 7'b1110000}, '{4'd7, 7'b1000111}, '{4'd8, 7'b1100111},
                 '{4'd9, 7'b0001110}, '{4'd10, 7'b0110111}, '{4'd11, 7'b0000001},
                 '{4'd12, 7'b1111110}, '{4'd13, 7'b1001111}, '{4'd14, 7'b0000000},
                 '{4'd15, 7'b0000000}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'd0);
        check("rst_a_g", 32'(a_g), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load 7,8,9,4: blank until the first boundary, then shown
        load_step({4'd4, 4'd9, 4'd8, 4'd7});
        nz = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            step();
            if (an != 0 || a_g != 0) nz++;
        end
        check("blank_before_boundary", 32'(nz), 32'd0);
        wait_frame();
        check("t1_slot0_an", 32'(an), 32'b1000);
        check("t1_slot0_a_g", 32'(a_g), 32'b1000111);

        // Mid-frame load of 0,1,2,3 must not disturb slots 1..3
        steps(15);
        load_step({4'd3, 4'd2, 4'd1, 4'd0});
        check("t2_slot1_a_g", 32'(a_g), 32'b1100111);
        steps(16);
        check("t2_slot2_a_g", 32'(a_g), 32'b0001110);
        steps(16);
        check("t1_slot3_an", 32'(an), 32'b0001);
        check("t1_slot3_a_g", 32'(a_g), 32'b1011011);
        wait_frame();
        check("t2_new_slot0_a_g", 32'(a_g), 32'b0110000);

        // duty=1: 8 lit cycles per 16-cycle slot
        duty = 2'd1;
        wait_frame();
        for (int k = 0; k < DIGITS; k++) dcnt[k] = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            for (int k = 0; k < DIGITS; k++) if (an[DIGITS-1-k]) dcnt[k]++;
        end
        for (int k = 0; k < DIGITS; k++) check($sformatf("t3_lit_cycles_d%0d", k), 32'(dcnt[k]), 32'd8);

        // Blink on digit 2
        duty = 2'd3;
        blink_mask = 4'b0100;
        steps(256);
        blink_mask = 4'b0000;

        // Blank codes in digits 1 and 3
        load_step({4'd15, 4'd6, 4'd14, 4'd5});
        steps(128);

        // Async reset mid-slot
        wait_frame();
        steps(2);
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'd0);
        check("async_rst_a_g", 32'(a_g), 32'd0);
        check("async_rst_frame_start", 32'(frame_start), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("restart_frame_start", 32'(frame_start), 32'd1);
        nz = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (an != 0 || a_g != 0) nz++;
        end
        check("blank_after_reset", 32'(nz), 32'd0);

        // Load in the boundary cycle lands in that frame's slot 0
        while ((mn % FRAME) != FRAME - 1) step();
        load_step({4'd0, 4'd0, 4'd0, 4'd13});
        step();
        check("boundary_load_an", 32'(an), 32'b1000);
        check("boundary_load_a_g", 32'(a_g), 32'b1001111);

        // Glyph table vectors, shown in slot 0
        for (int v = 0; v < 16; v++) begin
            load_step({4{vecs[v].code}});
            do step(); while ((mn % FRAME) != 1);
            check($sformatf("glyph_%0d_a_g", vecs[v].code), 32'(a_g), 32'(vecs[v].seg));
            check($sformatf("glyph_%0d_an", vecs[v].code), 32'(an),
                  (vecs[v].code < 4'd14) ? 32'b1000 : 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) blink_mask = 4'($urandom);
            if ($urandom_range(0, 99) < 3) duty = 2'($urandom);
            if ($urandom_range(0, 99) < 5) load_step(16'($urandom));
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
